// File: rtl/simon_key_sched_iter.sv
// simon_key_sched_iter: iterative Simon key expansion streaming one round key per handshake
module simon_key_sched_iter #(
    parameter int          N = 16,
    parameter int          M = 4,
    parameter int          T = 32,
    parameter logic [61:0] Z = 62'b01100111000011010100100010111110110011100001101010010001011111
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [M*N-1:0]       keytext,
    output logic                 busy,
    output logic                 rk_valid,
    input  logic                 rk_ready,
    output logic [N-1:0]         rk_data,
    output logic [$clog2(T)-1:0] rk_index,
    output logic                 rk_last,
    output logic                 done
);
    localparam int           IW   = $clog2(T);
    localparam logic [0:0]   IDLE = 1'b0;
    localparam logic [0:0]   RUN  = 1'b1;
    localparam logic [N-1:0] C    = {{(N-2){1'b1}}, 2'b00};

    logic [0:0]           state;
    logic [0:M-1][N-1:0]  win;
    logic [0:M-1][N-1:0]  win_nxt;
    logic [IW-1:0]        idx;
    logic [5:0]           zi;
    logic [N-1:0]         r3;
    logic [N-1:0]         tmp;
    logic [N-1:0]         nk;
    logic                 hs;
    logic                 fin;

    // win[0] is the key currently offered; win[M-1] is the newest key
    always_comb begin
        hs  = (state == RUN) && rk_ready;
        fin = hs && (idx == IW'(T - 1));
        r3  = {win[M-1][2:0], win[M-1][N-1:3]};
        tmp = (M == 4) ? (r3 ^ win[1]) : r3;
        nk  = win[0] ^ tmp ^ {tmp[0], tmp[N-1:1]} ^ C ^ {{(N-1){1'b0}}, Z[zi]};
        win_nxt = win;
        for (int j = 0; j < M - 1; j++) win_nxt[j] = win[j+1];
        win_nxt[M-1] = nk;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            win   <= '0;
            idx   <= '0;
            zi    <= '0;
            done  <= 1'b0;
        end else begin
            done <= fin;
            if (state == IDLE) begin
                if (start) begin
                    state <= RUN;
                    win   <= keytext;
                    idx   <= '0;
                    zi    <= '0;
                end
            end else if (hs) begin
                // the final key stays in the window so rk_data holds its last value
                if (fin) begin
                    state <= IDLE;
                end else begin
                    win <= win_nxt;
                    idx <= idx + IW'(1);
                    zi  <= (zi == 6'd61) ? 6'd0 : zi + 6'd1;
                end
            end
        end
    end

    assign busy     = (state == RUN);
    assign rk_valid = (state == RUN);
    assign rk_data  = win[0];
    assign rk_index = idx;
    assign rk_last  = (state == RUN) && (idx == IW'(T - 1));
endmodule

// File: doc/simon_key_sched_iter.md
SIMON_KEY_SCHED_ITER -- requirements
Module: simon_key_sched_iter

Interface
REQ-001 SHALL have parameter N, default 16, word width in bits; legal values 16, 24, 32, 48, 64.
REQ-002 SHALL have parameter M, default 4, number of key words; legal values 2, 3, 4.
REQ-003 SHALL have parameter T, default 32, number of round keys produced per run; T > M.
REQ-004 SHALL have parameter Z, default 62'b01100111000011010100100010111110110011100001101010010001011111, the constant sequence, indexed LSB-first.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port start  input  1  begin a key-expansion run.
REQ-008 SHALL have port keytext  input  M*N  master key, sampled when start is accepted.
REQ-009 SHALL have port busy  output  1  high while a run is in progress.
REQ-010 SHALL have port rk_valid  output  1  rk_data holds a valid round key.
REQ-011 SHALL have port rk_ready  input  1  consumer accepts the round key.
REQ-012 SHALL have port rk_data  output  N  round key k[rk_index].
REQ-013 SHALL have port rk_index  output  clog2(T)  index i of the key on rk_data.
REQ-014 SHALL have port rk_last  output  1  high with rk_valid when rk_index = T-1.
REQ-015 SHALL have port done  output  1  one-cycle pulse at end of run.

Function
REQ-016 SHALL define key word j (0 <= j < M) as keytext[M*N-1-j*N -: N]; word 0 is the most significant.
REQ-017 SHALL use the constant c = 2^N - 4 (all ones except bits 1:0).
REQ-018 SHALL, for i >= M, compute tmp = k[i-1] rotated right by 3; if M = 4, tmp = tmp ^ k[i-3].
REQ-019 SHALL compute k[i] = k[i-M] ^ tmp ^ (tmp rotated right by 1) ^ c ^ Z[(i-M) mod 62]; the Z bit is XORed into bit 0 only.
REQ-020 SHALL keep all arithmetic N bits wide, with rotations modulo N.
REQ-021 SHALL hold only an M-word sliding window plus an index counter; it SHALL NOT keep a T-entry key store.
REQ-022 SHALL implement FSM IDLE -> RUN on start while in IDLE, and RUN -> IDLE on the handshake with rk_last=1.
REQ-023 SHALL, in IDLE, load the window from keytext when start=1 at the clock edge; busy and rk_valid rise in the next cycle with rk_index=0.
REQ-024 SHALL ignore start while busy=1, including the cycle of the final handshake.
REQ-025 SHALL output k[0..M-1] directly from the window, then one generated key per accepted handshake.
REQ-026 SHALL, on handshake (rk_valid & rk_ready), advance to the next key in the next cycle, so sustained throughput is one key per cycle.
REQ-027 SHALL, when rk_valid=1 and rk_ready=0, hold rk_data, rk_index and rk_last stable; rk_valid SHALL NOT drop before the handshake.
REQ-028 SHALL drive rk_valid=1 continuously in RUN; rk_index SHALL increment by 1 per handshake, never skip, and never wrap within a run.
REQ-029 SHALL, in the cycle after the final handshake, pulse done=1 with busy=0 and rk_valid=0; start is accepted in that cycle.
REQ-030 SHALL produce a rk_data value that is don't-care when rk_valid=0, but deterministic (held at last value).

Reset
REQ-031 SHALL, on rst_n=0, immediately clear to IDLE with busy=0, rk_valid=0, rk_last=0, done=0, rk_index=0, rk_data=0 and window=0, independent of clk.
REQ-032 SHALL, on reset mid-run, abandon the run; no done pulse follows, and a new start is needed after rst_n is released.
REQ-033 SHALL take the first start accepted at the first rising edge with rst_n=1.

Verification
REQ-034 SHALL cover: defaults, keytext=64'h0100_0908_1110_1918, rk_ready=1 -> keys 0100,0908,1110,1918,71C3,B649 on consecutive cycles; 32 keys total, rk_last at index 31; done one cycle later.
REQ-035 SHALL cover: same run with rk_ready toggled randomly -> identical key sequence; outputs stable during every stall.
REQ-036 SHALL cover: start pulsed at index 10 and again in the final-handshake cycle -> both ignored; start in the done cycle -> new run from index 0.
REQ-037 SHALL cover: rst_n asserted at index 17 -> all outputs 0 asynchronously; no done pulse; a fresh run matches REQ-034.
REQ-038 SHALL cover: N=24, M=3, T=36, Z=z1 and N=64, M=2, T=68, Z=z2 -> every key equal to a software golden model.
